// File: rtl/ifq_multi_if.sv
// ifq_multi_if: fetch-group push, decode pop and head-window signals of the multi-lane fetch queue.
interface ifq_multi_if #(
    parameter int XLEN  = 32,
    parameter int LANES = 2,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(LANES + 1);
    localparam int PW = $clog2(DEPTH);
    logic                  flush;
    logic                  push_valid;
    logic [CW-1:0]         push_cnt;
    logic [XLEN-1:0]       push_pc;
    logic [LANES*XLEN-1:0] push_inst;
    logic                  push_ready;
    logic [CW-1:0]         pop_cnt;
    logic [LANES-1:0]      out_valid;
    logic [LANES*XLEN-1:0] out_pc;
    logic [LANES*XLEN-1:0] out_inst;
    logic [PW:0]           count;
    modport master (
        output flush, push_valid, push_cnt, push_pc, push_inst, pop_cnt,
        input  push_ready, out_valid, out_pc, out_inst, count
    );
    modport slave (
        input  flush, push_valid, push_cnt, push_pc, push_inst, pop_cnt,
        output push_ready, out_valid, out_pc, out_inst, count
    );
endinterface

// File: rtl/ifq_multi.sv
// ifq_multi: circular instruction fetch queue, accepts up to LANES entries per cycle and shows a LANES-wide head window.
module ifq_multi #(
    parameter int              XLEN     = 32,
    parameter int              LANES    = 2,
    parameter int              DEPTH    = 8,
    parameter logic [XLEN-1:0] NOP_INST = 32'h00000013
) (
    input logic        clk,
    input logic        rst,
    ifq_multi_if.slave q
);
    localparam int CW = $clog2(LANES + 1);
    localparam int PW = $clog2(DEPTH);
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] inst_mem [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [PW:0]     count, pushed, popped, pop_ext;
    logic            accept;
    // ready depends only on registered occupancy so decode's pop_cnt never reaches it
    assign q.push_ready = ((PW+1)'(DEPTH) - count) >= (PW+1)'(LANES);
    assign accept  = q.push_valid & q.push_ready & ~q.flush & (q.push_cnt != '0) & (q.push_cnt <= CW'(LANES));
    assign pushed  = accept ? (PW+1)'(q.push_cnt) : '0;
    assign pop_ext = (PW+1)'(q.pop_cnt);
    assign popped  = (pop_ext > count) ? count : pop_ext;
    assign q.count = count;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (q.flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count  <= count + pushed - popped;
            rd_ptr <= rd_ptr + popped[PW-1:0];
            wr_ptr <= wr_ptr + pushed[PW-1:0];
        end
    end
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if ((PW+1)'(i) < pushed) begin
                pc_mem[wr_ptr + PW'(i)]   <= q.push_pc + XLEN'(4 * i);
                inst_mem[wr_ptr + PW'(i)] <= q.push_inst[i*XLEN +: XLEN];
            end
        end
    end
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [PW-1:0] idx;
        logic          lv;
        assign idx = rd_ptr + PW'(i);
        assign lv  = count > (PW+1)'(i);
        assign q.out_valid[i]              = lv;
        assign q.out_pc[i*XLEN +: XLEN]   = lv ? pc_mem[idx] : '0;
        assign q.out_inst[i*XLEN +: XLEN] = lv ? inst_mem[idx] : NOP_INST;
    end
endmodule

// File: tb/tb_ifq_multi.sv
// tb_ifq_multi: directed scoreboard bench for ifq_multi (XLEN=32, LANES=2, DEPTH=8).
module tb_ifq_multi;
    localparam logic [31:0] N = 32'h00000013;
    typedef struct {
        string       nm;
        logic [3:0]  cnt;
        logic [1:0]  vld;
        logic        pr;
        logic [63:0] pc;
        logic [63:0] inst;
    } exp_t;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   fails  = 0;
    exp_t sb[$];
    event sample;
    ifq_multi_if #(.XLEN(32), .LANES(2), .DEPTH(8)) q ();
    ifq_multi #(.XLEN(32), .LANES(2), .DEPTH(8), .NOP_INST(32'h00000013)) dut (
        .clk(clk),
        .rst(rst),
        .q  (q)
    );
    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        #2;
        ->sample;
    end
    initial forever begin
        exp_t e;
        @(sample);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (q.count !== e.cnt || q.out_valid !== e.vld || q.push_ready !== e.pr ||
                q.out_pc !== e.pc || q.out_inst !== e.inst) begin
                fails++;
                $display("FAIL %s: got cnt=%0d vld=%b rdy=%b pc=%h inst=%h, want cnt=%0d vld=%b rdy=%b pc=%h inst=%h",
                         e.nm, q.count, q.out_valid, q.push_ready, q.out_pc, q.out_inst,
                         e.cnt, e.vld, e.pr, e.pc, e.inst);
            end
        end
    end
    function automatic exp_t mk(input string nm, input logic [3:0] cnt, input logic [1:0] vld, input logic pr,
                                input logic [31:0] pc0, input logic [31:0] i0,
                                input logic [31:0] pc1, input logic [31:0] i1);
        exp_t e;
        e.nm = nm; e.cnt = cnt; e.vld = vld; e.pr = pr;
        e.pc = {pc1, pc0}; e.inst = {i1, i0};
        return e;
    endfunction
    task automatic drive(input logic fl, input logic pv, input logic [1:0] pcn, input logic [31:0] ppc,
                         input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] popc);
        q.flush = fl; q.push_valid = pv; q.push_cnt = pcn; q.push_pc = ppc;
        q.push_inst = {i1, i0}; q.pop_cnt = popc;
    endtask
    task automatic cyc(input string nm, input logic fl, input logic pv, input logic [1:0] pcn,
                       input logic [31:0] ppc, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [1:0] popc, input logic [3:0] cnt, input logic [1:0] vld, input logic pr,
                       input logic [31:0] e_pc0, input logic [31:0] e_i0,
                       input logic [31:0] e_pc1, input logic [31:0] e_i1);
        drive(fl, pv, pcn, ppc, i0, i1, popc);
        sb.push_back(mk(nm, cnt, vld, pr, e_pc0, e_i0, e_pc1, e_i1));
        @(posedge clk);
        #1;
    endtask
    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(mk("reset", 0, 2'b00, 1, 0, N, 0, N));
        rst = 1'b0;
        cyc("push2",      0, 1, 2, 32'h10000, 32'h00500093, 32'h00a00113, 0, 2, 2'b11, 1, 32'h10000, 32'h00500093, 32'h10004, 32'h00a00113);
        cyc("pop1",       0, 0, 0, 0, 0, 0, 1, 1, 2'b01, 1, 32'h10004, 32'h00a00113, 0, N);
        cyc("pop_clamp",  0, 0, 0, 0, 0, 0, 2, 0, 2'b00, 1, 0, N, 0, N);
        cyc("fill_a",     0, 1, 2, 32'h200, 1, 2, 0, 2, 2'b11, 1, 32'h200, 1, 32'h204, 2);
        cyc("fill_b",     0, 1, 2, 32'h300, 3, 4, 0, 4, 2'b11, 1, 32'h200, 1, 32'h204, 2);
        cyc("fill_c",     0, 1, 2, 32'h400, 5, 6, 0, 6, 2'b11, 1, 32'h200, 1, 32'h204, 2);
        cyc("fill_d",     0, 1, 2, 32'h500, 7, 8, 0, 8, 2'b11, 0, 32'h200, 1, 32'h204, 2);
        cyc("full_hold",  0, 1, 2, 32'h600, 9, 10, 0, 8, 2'b11, 0, 32'h200, 1, 32'h204, 2);
        cyc("full_pop",   0, 1, 2, 32'h600, 9, 10, 2, 6, 2'b11, 1, 32'h300, 3, 32'h304, 4);
        cyc("push_pop",   0, 1, 2, 32'h700, 11, 12, 2, 6, 2'b11, 1, 32'h400, 5, 32'h404, 6);
        cyc("pop_d",      0, 0, 0, 0, 0, 0, 2, 4, 2'b11, 1, 32'h500, 7, 32'h504, 8);
        cyc("pop_e",      0, 0, 0, 0, 0, 0, 2, 2, 2'b11, 1, 32'h700, 11, 32'h704, 12);
        cyc("pp_800",     0, 1, 2, 32'h800, 13, 14, 2, 2, 2'b11, 1, 32'h800, 13, 32'h804, 14);
        cyc("push1_900",  0, 1, 1, 32'h900, 15, 0, 0, 3, 2'b11, 1, 32'h800, 13, 32'h804, 14);
        cyc("pop_to_900", 0, 0, 0, 0, 0, 0, 2, 1, 2'b01, 1, 32'h900, 15, 0, N);
        cyc("push1_wr7",  0, 1, 1, 32'ha00, 16, 0, 0, 2, 2'b11, 1, 32'h900, 15, 32'ha00, 16);
        cyc("push2_wrap", 0, 1, 2, 32'hb00, 17, 18, 0, 4, 2'b11, 1, 32'h900, 15, 32'ha00, 16);
        cyc("win_wrap",   0, 0, 0, 0, 0, 0, 1, 3, 2'b11, 1, 32'ha00, 16, 32'hb00, 17);
        cyc("pop_wrap",   0, 0, 0, 0, 0, 0, 2, 1, 2'b01, 1, 32'hb04, 18, 0, N);
        cyc("cnt0_rej",   0, 1, 0, 32'hc00, 33, 34, 0, 1, 2'b01, 1, 32'hb04, 18, 0, N);
        cyc("cnt3_rej",   0, 1, 3, 32'hc00, 33, 34, 0, 1, 2'b01, 1, 32'hb04, 18, 0, N);
        cyc("fill5_a",    0, 1, 2, 32'hc00, 33, 34, 0, 3, 2'b11, 1, 32'hb04, 18, 32'hc00, 33);
        cyc("fill5_b",    0, 1, 2, 32'hd00, 35, 36, 0, 5, 2'b11, 1, 32'hb04, 18, 32'hc00, 33);
        cyc("flush",      1, 1, 2, 32'hdd0, 51, 52, 2, 0, 2'b00, 1, 0, N, 0, N);
        cyc("post_flush", 0, 1, 2, 32'he00, 37, 38, 0, 2, 2'b11, 1, 32'he00, 37, 32'he04, 38);
        cyc("fill4",      0, 1, 2, 32'hf00, 39, 40, 0, 4, 2'b11, 1, 32'he00, 37, 32'he04, 38);
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        sb.push_back(mk("async_rst", 0, 2'b00, 1, 0, N, 0, N));
        ->sample;
        #1;
        rst = 1'b0;
        #1;
        cyc("post_rst",   0, 1, 2, 32'h1000, 49, 50, 0, 2, 2'b11, 1, 32'h1000, 49, 32'h1004, 50);
        cyc("drain_pop",  0, 0, 0, 0, 0, 0, 3, 0, 2'b00, 1, 0, N, 0, N);
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
